// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO configuration chain loader: word layout,
// software reset word and the loader state encoding.
package gpio_cfg_pkg;

    localparam int CFG_BITS = 13;

    localparam int CFG_MGMT_ENA    = 12;
    localparam int CFG_OUTENB      = 11;
    localparam int CFG_HOLDOVER    = 10;
    localparam int CFG_INP_DIS     = 9;
    localparam int CFG_IB_MODE_SEL = 8;
    localparam int CFG_ANALOG_EN   = 7;
    localparam int CFG_ANALOG_SEL  = 6;
    localparam int CFG_ANALOG_POL  = 5;
    localparam int CFG_SLOW_SEL    = 4;
    localparam int CFG_VTRIP_SEL   = 3;
    localparam int CFG_DM_MSB      = 2;
    localparam int CFG_DM_LSB      = 0;

    // Management-owned, output disabled, digital mode 3'b011
    localparam logic [CFG_BITS-1:0] CFG_RESET_WORD = 13'h1803;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH0   = 3'd1,
        S_FETCH1   = 3'd2,
        S_SHIFT_LO = 3'd3,
        S_SHIFT_HI = 3'd4,
        S_LOAD     = 3'd5,
        S_DONE     = 3'd6
    } loader_state_t;

endpackage

// File: rtl/gpio_serial_phase.sv
// Phase timer for the serial chain: counts CLK_DIV cycles within a state and
// flags the last one. Restarts whenever the loader changes state.
module gpio_serial_phase #(
    parameter int CLK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic phase_last
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign phase_last = (cnt_q == CW'(CLK_DIV - 1));

    // Next count: restart on state entry or after the last phase cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (phase_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts one configuration word per pad into the daisy-chained GPIO control
// blocks (far pad first, MSB first), then strobes a common load.
module gpio_serial_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = gpio_cfg_pkg::CFG_BITS,
    parameter int CLK_DIV  = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(NUM_PADS)-1:0] cfg_addr,
    input  logic [CFG_BITS-1:0]         cfg_data,
    output logic                        serial_clock,
    output logic                        serial_data,
    output logic                        serial_load
);

    import gpio_cfg_pkg::*;

    localparam int AW = $clog2(NUM_PADS);
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    loader_state_t       state_q, state_d;
    logic [AW-1:0]       pad_idx_q, pad_idx_d;
    logic [BW-1:0]       bit_idx_q, bit_idx_d;
    logic [CFG_BITS-1:0] shreg_q, shreg_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sclk_q, sclk_d;
    logic                sdata_q, sdata_d;
    logic                sload_q, sload_d;
    logic                phase_last_s;
    logic                state_change_s;

    assign state_change_s = (state_d != state_q);

    gpio_serial_phase #(.CLK_DIV(CLK_DIV)) u_phase (
        .clock      (clock),
        .reset      (reset),
        .clear      (state_change_s),
        .phase_last (phase_last_s)
    );

    // State, counters, shift register and all registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pad_idx_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sload_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pad_idx_q <= pad_idx_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            sload_q   <= sload_d;
        end
    end

    // Next state and datapath updates; start is only looked at in idle
    always_comb begin
        state_d   = state_q;
        pad_idx_d = pad_idx_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pad_idx_d = AW'(NUM_PADS - 1);
                    state_d   = S_FETCH0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: begin
                shreg_d   = cfg_data;
                bit_idx_d = BW'(CFG_BITS - 1);
                state_d   = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (phase_last_s) begin
                    state_d = S_SHIFT_HI;
                end else begin
                    state_d = S_SHIFT_LO;
                end
            end
            S_SHIFT_HI: begin
                if (phase_last_s) begin
                    shreg_d = {shreg_q[CFG_BITS-2:0], 1'b0};
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - BW'(1);
                        state_d   = S_SHIFT_LO;
                    end else if (pad_idx_q != '0) begin
                        pad_idx_d = pad_idx_q - AW'(1);
                        state_d   = S_FETCH0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_SHIFT_HI;
                end
            end
            S_LOAD: begin
                if (phase_last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they land in flops aligned with it
    always_comb begin
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        sclk_d  = (state_d == S_SHIFT_HI);
        sload_d = (state_d == S_LOAD);
        if (state_d == S_FETCH0) begin
            addr_d = pad_idx_d;
        end else begin
            addr_d = addr_q;
        end
        // Data only moves on entry to the low phase, so it is stable across the rise
        if (state_d == S_SHIFT_LO) begin
            sdata_d = shreg_d[CFG_BITS-1];
        end else begin
            sdata_d = sdata_q;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_addr     = addr_q;
    assign serial_clock = sclk_q;
    assign serial_data  = sdata_q;
    assign serial_load  = sload_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: three instances (2 pads div 1, 2 pads div 3,
// full 38-pad chain) with a chain scoreboard and timing monitor per instance.
module tb_gpio_serial_loader;

    logic        clock;
    logic [2:0]  rst, start, clr;
    logic [2:0]  busy_w, done_w, sclk_w, sdata_w, sload_w;
    logic [0:0]  addr_a, addr_b;
    logic [5:0]  addr_c;
    logic [5:0]  addr_x [3];
    logic [12:0] cfg_d [3];
    logic [12:0] mem [3][38];

    int           busy_cnt [3], done_cnt [3], load_cnt [3], sedge [3];
    int           viol [3], stable [3], hi_run [3];
    logic [493:0] chain [3], latched [3];
    logic [2:0]   sclk_p, sdata_p;
    int           tests, fails;

    gpio_serial_loader #(.NUM_PADS(2), .CFG_BITS(13), .CLK_DIV(1)) u_dut_a (
        .clock(clock), .reset(rst[0]), .start(start[0]), .busy(busy_w[0]), .done(done_w[0]),
        .cfg_addr(addr_a), .cfg_data(cfg_d[0]), .serial_clock(sclk_w[0]),
        .serial_data(sdata_w[0]), .serial_load(sload_w[0]));

    gpio_serial_loader #(.NUM_PADS(2), .CFG_BITS(13), .CLK_DIV(3)) u_dut_b (
        .clock(clock), .reset(rst[1]), .start(start[1]), .busy(busy_w[1]), .done(done_w[1]),
        .cfg_addr(addr_b), .cfg_data(cfg_d[1]), .serial_clock(sclk_w[1]),
        .serial_data(sdata_w[1]), .serial_load(sload_w[1]));

    gpio_serial_loader u_dut_c (
        .clock(clock), .reset(rst[2]), .start(start[2]), .busy(busy_w[2]), .done(done_w[2]),
        .cfg_addr(addr_c), .cfg_data(cfg_d[2]), .serial_clock(sclk_w[2]),
        .serial_data(sdata_w[2]), .serial_load(sload_w[2]));

    assign addr_x[0] = {5'd0, addr_a};
    assign addr_x[1] = {5'd0, addr_b};
    assign addr_x[2] = addr_c;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Config register file: data follows the address by one cycle
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) cfg_d[i] <= mem[i][addr_x[i]];
    end

    // Chain model plus setup/hold and phase-length monitor
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (clr[i]) begin
                busy_cnt[i] <= 0; done_cnt[i] <= 0; load_cnt[i] <= 0; sedge[i] <= 0;
                viol[i] <= 0; stable[i] <= 0; hi_run[i] <= 0;
                chain[i] <= '0; latched[i] <= '0;
            end else begin
                if (busy_w[i]) busy_cnt[i] <= busy_cnt[i] + 1;
                if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
                if (sload_w[i]) begin
                    load_cnt[i] <= load_cnt[i] + 1;
                    latched[i]  <= chain[i];
                end
                if (sclk_w[i] && !sclk_p[i]) begin
                    chain[i] <= {chain[i][492:0], sdata_w[i]};
                    sedge[i] <= sedge[i] + 1;
                end
                viol[i] <= viol[i]
                    + int'(sclk_w[i] && !sclk_p[i] && stable[i] < ((i == 1) ? 3 : 1))
                    + int'(sclk_w[i] && sclk_p[i] && sdata_w[i] !== sdata_p[i])
                    + int'(!sclk_w[i] && sclk_p[i] && hi_run[i] != ((i == 1) ? 3 : 1));
                hi_run[i] <= sclk_w[i] ? hi_run[i] + 1 : 0;
                stable[i] <= (sdata_w[i] !== sdata_p[i]) ? 1 : stable[i] + 1;
            end
            sclk_p[i]  <= sclk_w[i];
            sdata_p[i] <= sdata_w[i];
        end
    end

    task automatic clear_stats(input int i);
        @(posedge clock); #1 clr[i] = 1'b1;
        @(posedge clock); #1 clr[i] = 1'b0;
    endtask

    task automatic pulse_start(input int i);
        @(negedge clock); start[i] = 1'b1;
        @(negedge clock); start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int c = 0;
        while (done_cnt[i] == 0 && c < budget) begin
            @(negedge clock);
            c++;
        end
        tests++;
        if (done_cnt[i] == 0) begin
            fails++;
            $display("FAIL done_timeout[%0d]: no done within %0d cycles", i, budget);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset;
        start = 3'b000; rst = 3'b111; clr = 3'b000;
        @(posedge clock); #1 clr = 3'b111;
        @(posedge clock); #1 clr = 3'b000;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({busy_w[i], done_w[i], sclk_w[i], sdata_w[i], sload_w[i]} !== 5'b00000 || addr_x[i] !== 6'd0) begin
                fails++;
                $display("FAIL reset_outputs[%0d]: got bdcdl=%b%b%b%b%b addr=%0d, expected all 0", i,
                         busy_w[i], done_w[i], sclk_w[i], sdata_w[i], sload_w[i], addr_x[i]);
            end
        end
        rst = 3'b000;
    endtask

    task automatic test_basic_load;
        clear_stats(0);
        pulse_start(0);
        tests++;
        if (busy_w[0] !== 1'b1 || addr_a !== 1'b1) begin
            fails++;
            $display("FAIL start_latency: got busy=%b addr=%0d, expected busy=1 addr=1", busy_w[0], addr_a);
        end
        wait_done(0, 200);
        tests++;
        if (sedge[0] != 26) begin fails++; $display("FAIL basic_edges: got %0d, expected 26", sedge[0]); end
        tests++;
        if (latched[0] !== {468'd0, 13'h1ABC, 13'h0555}) begin
            fails++; $display("FAIL basic_chain: got %h, expected %h", latched[0][25:0], {13'h1ABC, 13'h0555});
        end
        tests++;
        if (load_cnt[0] != 1 || done_cnt[0] != 1) begin
            fails++; $display("FAIL basic_load_done: got load=%0d done=%0d, expected 1 1", load_cnt[0], done_cnt[0]);
        end
        tests++;
        if (busy_cnt[0] != 57) begin fails++; $display("FAIL basic_busy: got %0d, expected 57", busy_cnt[0]); end
        tests++;
        if (viol[0] != 0) begin fails++; $display("FAIL basic_timing: got %0d violations, expected 0", viol[0]); end
    endtask

    task automatic test_divider;
        clear_stats(1);
        pulse_start(1);
        wait_done(1, 400);
        tests++;
        if (busy_cnt[1] != 163) begin fails++; $display("FAIL div_busy: got %0d, expected 163", busy_cnt[1]); end
        tests++;
        if (sedge[1] != 26) begin fails++; $display("FAIL div_edges: got %0d, expected 26", sedge[1]); end
        tests++;
        if (latched[1] !== {468'd0, 13'h0F0F, 13'h1234}) begin
            fails++; $display("FAIL div_chain: got %h, expected %h", latched[1][25:0], {13'h0F0F, 13'h1234});
        end
        tests++;
        if (load_cnt[1] != 3) begin fails++; $display("FAIL div_load_len: got %0d, expected 3", load_cnt[1]); end
        tests++;
        if (viol[1] != 0) begin fails++; $display("FAIL div_timing: got %0d violations, expected 0", viol[1]); end
    endtask

    task automatic test_start_while_busy;
        int c = 0;
        clear_stats(0);
        pulse_start(0);
        repeat (20) @(negedge clock);
        pulse_start(0);
        while (!done_w[0] && c < 200) begin @(negedge clock); c++; end
        tests++;
        if (!done_w[0]) begin fails++; $display("FAIL swb_timeout: done never seen, expected within 200"); end
        start[0] = 1'b1;
        @(negedge clock); start[0] = 1'b0;
        tests++;
        if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL swb_done_start: got busy=%b, expected 0", busy_w[0]); end
        repeat (10) @(negedge clock);
        tests++;
        if (done_cnt[0] != 1 || load_cnt[0] != 1 || busy_cnt[0] != 57) begin
            fails++;
            $display("FAIL swb_single: got done=%0d load=%0d busy=%0d, expected 1 1 57", done_cnt[0], load_cnt[0], busy_cnt[0]);
        end
    endtask

    task automatic test_back_to_back;
        int c = 0;
        clear_stats(0);
        @(negedge clock); start[0] = 1'b1;
        while (!done_w[0] && c < 200) begin @(negedge clock); c++; end
        @(negedge clock);
        tests++;
        if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL b2b_idle: got busy=%b, expected 0", busy_w[0]); end
        @(negedge clock);
        start[0] = 1'b0;
        tests++;
        if (busy_w[0] !== 1'b1 || addr_a !== 1'b1) begin
            fails++; $display("FAIL b2b_restart: got busy=%b addr=%0d, expected 1 1", busy_w[0], addr_a);
        end
        c = 0;
        while (!done_w[0] && c < 200) begin @(negedge clock); c++; end
        repeat (3) @(negedge clock);
        tests++;
        if (done_cnt[0] != 2 || load_cnt[0] != 2 || busy_cnt[0] != 114) begin
            fails++;
            $display("FAIL b2b_counts: got done=%0d load=%0d busy=%0d, expected 2 2 114", done_cnt[0], load_cnt[0], busy_cnt[0]);
        end
    endtask

    task automatic test_reset_mid_shift;
        int c = 0;
        clear_stats(0);
        pulse_start(0);
        while (sedge[0] < 10 && c < 100) begin @(negedge clock); c++; end
        tests++;
        if (sedge[0] < 10) begin fails++; $display("FAIL rms_timeout: got %0d edges, expected 10", sedge[0]); end
        rst[0] = 1'b1;
        @(negedge clock);
        rst[0] = 1'b0;
        tests++;
        if ({busy_w[0], done_w[0], sclk_w[0], sdata_w[0], sload_w[0], addr_a} !== 6'b000000) begin
            fails++;
            $display("FAIL rms_outputs: got bdcdl=%b%b%b%b%b addr=%0d, expected all 0",
                     busy_w[0], done_w[0], sclk_w[0], sdata_w[0], sload_w[0], addr_a);
        end
        repeat (80) @(negedge clock);
        tests++;
        if (load_cnt[0] != 0 || done_cnt[0] != 0) begin
            fails++; $display("FAIL rms_no_load: got load=%0d done=%0d, expected 0 0", load_cnt[0], done_cnt[0]);
        end
        mem[0][1] = 13'h0A5A;
        mem[0][0] = 13'h1F00;
        clear_stats(0);
        pulse_start(0);
        wait_done(0, 200);
        tests++;
        if (latched[0] !== {468'd0, 13'h0A5A, 13'h1F00} || busy_cnt[0] != 57) begin
            fails++;
            $display("FAIL rms_recover: got chain=%h busy=%0d, expected %h 57", latched[0][25:0], busy_cnt[0], {13'h0A5A, 13'h1F00});
        end
    endtask

    task automatic test_reset_with_start;
        @(negedge clock); rst[0] = 1'b1; start[0] = 1'b1;
        @(negedge clock); rst[0] = 1'b0; start[0] = 1'b0;
        tests++;
        if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL rws_busy: got %b, expected 0", busy_w[0]); end
        @(negedge clock);
        tests++;
        if (busy_w[0] !== 1'b0 || addr_a !== 1'b0) begin
            fails++; $display("FAIL rws_idle: got busy=%b addr=%0d, expected 0 0", busy_w[0], addr_a);
        end
    endtask

    task automatic test_full_chain;
        logic [12:0] exp_w;
        clear_stats(2);
        pulse_start(2);
        wait_done(2, 1200);
        tests++;
        if (busy_cnt[2] != 1065) begin fails++; $display("FAIL full_busy: got %0d, expected 1065", busy_cnt[2]); end
        tests++;
        if (sedge[2] != 494 || load_cnt[2] != 1) begin
            fails++; $display("FAIL full_edges: got edges=%0d load=%0d, expected 494 1", sedge[2], load_cnt[2]);
        end
        for (int p = 0; p < 38; p++) begin
            exp_w = 13'(p) ^ 13'h1FFF;
            tests++;
            if (latched[2][p*13 +: 13] !== exp_w) begin
                fails++; $display("FAIL full_pad[%0d]: got %h, expected %h", p, latched[2][p*13 +: 13], exp_w);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mem[0][0] = 13'h0555; mem[0][1] = 13'h1ABC;
        mem[1][0] = 13'h1234; mem[1][1] = 13'h0F0F;
        for (int p = 0; p < 38; p++) mem[2][p] = 13'(p) ^ 13'h1FFF;
        test_reset;
        test_basic_load;
        test_divider;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_shift;
        test_reset_with_start;
        test_full_chain;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
